// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the IM-stage data-memory sequencer.
//   dmem_state_t : bus-sequencer state encoding
//   RES_*        : ResultSrc encodings carried down the pipe
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } dmem_state_t;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

endpackage

// File: rtl/watchdog_cnt.sv
// Access watchdog: counts cycles while en is high, clears on clr.
// Ports:
//   clk, reset_n : clock / async active-low reset
//   en           : count this cycle
//   clr          : synchronous clear (wins over en)
//   expire       : count has reached TIMEOUT_CYC-1
module watchdog_cnt #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at TIMEOUT_CYC and expire uses >=: a load granted exactly in the
  // timeout cycle moves on to WAIT_RSP with the count already past the limit,
  // and must still be bounded there.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && (cnt_q != CNT_W'(TIMEOUT_CYC)))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign expire = (cnt_q >= CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/dmem_access_ctrl.sv
// IM-stage data-memory access controller (req/gnt/rvalid handshake).
// Issues the load/store held in IE_IM, stalls the front pipe until the access
// completes, gates the E-stage flush, and converts bus errors / timeouts into
// W-stage bubbles plus a sticky fault flag.
// Ports:
//   clk, reset_n                  : clock / async active-low reset
//   MemWriteM, ResultSrcM         : op decode from IE_IM
//   ALUResultM, RD2M              : address / store data
//   flush_req                     : E-stage redirect request
//   dmem_gnt/rvalid/rdata/err     : memory response side
//   dmem_req/we/addr/wdata        : memory request side
//   stall, flush, bubble_w        : pipeline control
//   ReadDataM                     : load data into IM/IW
//   bus_fault                     : sticky error/timeout flag
module dmem_access_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] RD2M,
  input  logic        flush_req,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        stall,
  output logic        flush,
  output logic        bubble_w,
  output logic [31:0] ReadDataM,
  output logic        bus_fault
);

  dmem_state_t state_q, state_d;
  logic [31:0] rd_q;
  logic        fault_q;
  logic        op_m, is_st, wd_expire;
  logic        req, complete, fault_now, stall_int;

  assign is_st = MemWriteM;
  assign op_m  = MemWriteM | (ResultSrcM == RES_MEM);

  watchdog_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) u_wd (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (state_q != IDLE),
    .clr    (state_q == IDLE),
    .expire (wd_expire)
  );

  // A handshake in the timeout cycle always wins over the abort.
  always_comb begin
    state_d   = state_q;
    req       = 1'b0;
    complete  = 1'b0;
    fault_now = 1'b0;
    case (state_q)
      IDLE: if (op_m) begin
        req = 1'b1;
        if (dmem_gnt) begin
          if (is_st) begin
            complete  = 1'b1;
            fault_now = dmem_err;
          end else begin
            state_d = WAIT_RSP;
          end
        end else begin
          state_d = REQ;
        end
      end
      REQ: begin
        req = 1'b1;
        if (dmem_gnt) begin
          if (is_st) begin
            complete  = 1'b1;
            fault_now = dmem_err;
            state_d   = IDLE;
          end else begin
            state_d = WAIT_RSP;
          end
        end else if (wd_expire) begin
          complete  = 1'b1;
          fault_now = 1'b1;
          state_d   = IDLE;
        end
      end
      WAIT_RSP: begin
        if (dmem_rvalid) begin
          complete  = 1'b1;
          fault_now = dmem_err;
          state_d   = IDLE;
        end else if (wd_expire) begin
          complete  = 1'b1;
          fault_now = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rd_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (dmem_rvalid) rd_q <= dmem_rdata;
      if (fault_now)   fault_q <= 1'b1;
    end
  end

  // Stall drops in the completion cycle so IE_IM advances on that edge.
  assign stall_int = op_m & ~complete;

  // Pipeline-control outputs are forced low combinationally during reset.
  assign dmem_req   = reset_n & req;
  assign stall      = reset_n & stall_int;
  assign flush      = reset_n & flush_req & ~stall_int;
  assign bubble_w   = reset_n & fault_now;
  assign dmem_we    = MemWriteM & op_m;
  assign dmem_addr  = ALUResultM;
  assign dmem_wdata = RD2M;
  assign ReadDataM  = !reset_n ? 32'h0 : (dmem_rvalid ? dmem_rdata : rd_q);
  assign bus_fault  = fault_q;

endmodule
